// File: rtl/button_shaper_pkg.sv
// Purpose : shared definitions for the button shaper array (state encoding, counter sizing).
// Latency : n/a (declarations only).
// Backpressure: n/a.
package button_shaper_pkg;

   // Channel FSM state encoding
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_DEBOUNCE = 3'd1;
   localparam logic [2:0] ST_PULSE    = 3'd2;
   localparam logic [2:0] ST_HELD     = 3'd3;
   localparam logic [2:0] ST_RELEASE  = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE     = ST_IDLE,
      S_DEBOUNCE = ST_DEBOUNCE,
      S_PULSE    = ST_PULSE,
      S_HELD     = ST_HELD,
      S_RELEASE  = ST_RELEASE
   } state_e;

   // Bits needed to hold values 0..max_val-1 (never less than one bit).
   function automatic int cnt_width(input int max_val);
      return (max_val > 1) ? $clog2(max_val) : 1;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/button_shaper_channel.sv
// Purpose : one button channel: 2-flop synchronizer, debounce, press pulse and auto-repeat.
// Latency : first pulse is registered DEBOUNCE_CYCLES+3 edges after the raw input goes high.
// Backpressure: none; pulses are fire-and-forget.
// Ports   : clk, rst (async, active-high), btn_in (raw async level), repeat_en (sync),
//           pulse (one-cycle press pulse), level (debounced pressed level).
module button_shaper_channel
   import button_shaper_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 16,
   parameter int REPEAT_PERIOD   = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   input  logic repeat_en,
   output logic pulse,
   output logic level
);

   localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam int CW      = cnt_width(CNT_MAX);

   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t DEB_LAST    = cnt_t'(DEBOUNCE_CYCLES - 1);
   localparam cnt_t DELAY_LAST  = cnt_t'(REPEAT_DELAY - 1);
   localparam cnt_t PERIOD_LAST = cnt_t'(REPEAT_PERIOD - 1);

   logic   sync1_q, sync1_d;
   logic   btn_s_q, btn_s_d;
   state_e state_q, state_d;
   cnt_t   cnt_q, cnt_d;
   logic   first_rep_q, first_rep_d;
   logic   pulse_q, pulse_d;
   logic   level_q, level_d;
   cnt_t   rep_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= 1'b0;
         btn_s_q     <= 1'b0;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         first_rep_q <= 1'b0;
         pulse_q     <= 1'b0;
         level_q     <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         btn_s_q     <= btn_s_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         first_rep_q <= first_rep_d;
         pulse_q     <= pulse_d;
         level_q     <= level_d;
      end
   end

   always_comb begin
      sync1_d     = btn_in;
      btn_s_d     = sync1_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      first_rep_d = first_rep_q;
      // First repeat waits the long delay, later ones the shorter period.
      rep_last    = first_rep_q ? DELAY_LAST : PERIOD_LAST;

      case (state_q)
         S_IDLE: begin
            if (btn_s_q) begin
               state_d = S_DEBOUNCE;
               cnt_d   = '0;
            end
         end
         S_DEBOUNCE: begin
            if (!btn_s_q) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d     = S_PULSE;
               first_rep_d = 1'b1;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + cnt_t'(1);
            end
         end
         S_PULSE: begin
            // Exactly one cycle, input ignored.
            state_d = S_HELD;
            cnt_d   = '0;
         end
         S_HELD: begin
            if (!btn_s_q) begin
               state_d = S_RELEASE;
               cnt_d   = '0;
            end else if (!repeat_en) begin
               cnt_d = '0;
            end else if (cnt_q == rep_last) begin
               state_d     = S_PULSE;
               first_rep_d = 1'b0;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + cnt_t'(1);
            end
         end
         S_RELEASE: begin
            // A short dropout returns to HELD; the repeat timer restarts but
            // first_rep is kept so the repeat phase is not reset.
            if (btn_s_q) begin
               state_d = S_HELD;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + cnt_t'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Outputs are registered copies of the next-state decode, so they line
      // up with state_q while coming straight from flops.
      pulse_d = (state_d == S_PULSE);
      level_d = (state_d == S_PULSE) || (state_d == S_HELD) || (state_d == S_RELEASE);
   end

   assign pulse = pulse_q;
   assign level = level_q;

endmodule

// File: rtl/button_shaper_array.sv
// Purpose : NUM_BTN independent debounced button channels with press pulse and auto-repeat.
// Latency : press pulse DEBOUNCE_CYCLES+3 edges after raw press; Btt_any is combinational on Btt_out.
// Backpressure: none.
// Ports   : clk, rst (async, active-high), Btt_in (raw levels), repeat_en (per channel),
//           Btt_out (one-cycle pulses), Btt_level (debounced level), Btt_any (OR of Btt_out).
module button_shaper_array
   import button_shaper_pkg::*;
#(
   parameter int NUM_BTN         = 4,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 16,
   parameter int REPEAT_PERIOD   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] Btt_in,
   input  logic [NUM_BTN-1:0] repeat_en,
   output logic [NUM_BTN-1:0] Btt_out,
   output logic [NUM_BTN-1:0] Btt_level,
   output logic               Btt_any
);

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
      button_shaper_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .btn_in    (Btt_in[g]),
         .repeat_en (repeat_en[g]),
         .pulse     (Btt_out[g]),
         .level     (Btt_level[g])
      );
   end

   assign Btt_any = |Btt_out;

endmodule

// File: tb/tb_button_shaper_array.sv
module tb_button_shaper_array;

   localparam int N  = 4;
   localparam int D  = 4;
   localparam int RD = 16;
   localparam int RP = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] Btt_in;
   logic [N-1:0] repeat_en;
   logic [N-1:0] Btt_out;
   logic [N-1:0] Btt_level;
   logic         Btt_any;

   always #10 clk = ~clk;

   button_shaper_array #(
      .NUM_BTN         (N),
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .Btt_in    (Btt_in),
      .repeat_en (repeat_en),
      .Btt_out   (Btt_out),
      .Btt_level (Btt_level),
      .Btt_any   (Btt_any)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: the raw input reaches the decision logic two edges late.
   // A press is accepted after D+1 consecutive high samples, a release after
   // D+1 consecutive low samples; while held, repeat pulses come every
   // RD (first) or RP (later) repeat-enabled high samples after the edge that
   // follows a pulse. A high sample during a release attempt restarts the timer.
   bit m_s1[N], m_s2[N];
   bit m_lvl[N], m_pulse[N], m_first[N];
   int hi_run[N], lo_run[N], hold_t[N];

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_pulse[i] = 0; m_first[i] = 0;
         hi_run[i] = 0; lo_run[i] = 0; hold_t[i] = 0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < N; i++) begin
         bit s;
         s = m_s2[i];
         m_s2[i] = m_s1[i];
         m_s1[i] = Btt_in[i];
         if (m_pulse[i]) begin
            m_pulse[i] = 0; hold_t[i] = 0; lo_run[i] = 0;
         end else if (!m_lvl[i]) begin
            hi_run[i] = s ? hi_run[i] + 1 : 0;
            if (hi_run[i] == D + 1) begin
               m_pulse[i] = 1; m_lvl[i] = 1; m_first[i] = 1; hi_run[i] = 0;
            end
         end else if (s) begin
            if (lo_run[i] > 0) begin
               lo_run[i] = 0; hold_t[i] = 0;
            end else if (!repeat_en[i]) begin
               hold_t[i] = 0;
            end else begin
               hold_t[i]++;
               if (hold_t[i] == (m_first[i] ? RD : RP)) begin
                  m_pulse[i] = 1; m_first[i] = 0; hold_t[i] = 0;
               end
            end
         end else begin
            lo_run[i]++;
            if (lo_run[i] == D + 1) begin
               m_lvl[i] = 0; lo_run[i] = 0; hi_run[i] = 0;
            end
         end
      end
   endtask

   // One clock: update the model at the edge, compare 1 ns later.
   task automatic tick();
      logic [N-1:0] eo, el;
      @(posedge clk);
      model_edge();
      #1;
      for (int i = 0; i < N; i++) begin
         eo[i] = m_pulse[i];
         el[i] = m_lvl[i];
      end
      chk("btt_out", 32'(Btt_out), 32'(eo));
      chk("btt_level", 32'(Btt_level), 32'(el));
      chk("btt_any", 32'(Btt_any), 32'(|eo));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_out", 32'(Btt_out), 0);
      chk("rst_level", 32'(Btt_level), 0);
      chk("rst_any", 32'(Btt_any), 0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Ticks until channel ch pulses; returns -1 if none within the budget.
   task automatic wait_pulse(input int ch, output int n);
      n = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (Btt_out[ch]) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      int n;
      int cnt;
      int ptimes[$];
      bit seen;

      Btt_in    = '0;
      repeat_en = '0;
      rst       = 1'b1;
      #1;
      model_reset();
      #14;
      chk("init_out", 32'(Btt_out), 0);
      chk("init_level", 32'(Btt_level), 0);
      chk("init_any", 32'(Btt_any), 0);
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      // Press latency on channel 0
      Btt_in[0] = 1'b1;
      wait_pulse(0, n);
      chk("press_lat", 32'(n), 32'(D + 3));
      idle(10);
      chk("held_level", 32'(Btt_level[0]), 1);

      // Short dropout during hold keeps the level, no new pulse
      Btt_in[0] = 1'b0;
      idle(2);
      Btt_in[0] = 1'b1;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (Btt_out[0] || !Btt_level[0]) seen = 1;
      end
      chk("dropout_hold", 32'(seen), 0);

      // Long low ends the hold
      Btt_in[0] = 1'b0;
      idle(10);
      chk("release_level", 32'(Btt_level[0]), 0);

      // Short press glitch on channel 1 never pulses
      Btt_in[1] = 1'b1;
      idle(2);
      Btt_in[1] = 1'b0;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (Btt_out[1] || Btt_level[1]) seen = 1;
      end
      chk("glitch_press", 32'(seen), 0);

      // Auto-repeat spacing on channel 2
      repeat_en[2] = 1'b1;
      Btt_in[2]    = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (Btt_out[2]) ptimes.push_back(k);
      end
      chk("rep_count", 32'(ptimes.size()), 6);
      if (ptimes.size() >= 4) begin
         chk("rep_first", 32'(ptimes[0]), 32'(D + 3));
         chk("rep_gap1", 32'(ptimes[1] - ptimes[0]), 32'(RD + 1));
         chk("rep_gap2", 32'(ptimes[2] - ptimes[1]), 32'(RP + 1));
         chk("rep_gap3", 32'(ptimes[3] - ptimes[2]), 32'(RP + 1));
      end
      Btt_in[2] = 1'b0;
      idle(10);

      // No repeat when disabled
      repeat_en[2] = 1'b0;
      Btt_in[2]    = 1'b1;
      cnt = 0;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (Btt_out[2]) cnt++;
      end
      chk("norep_count", 32'(cnt), 1);
      Btt_in[2] = 1'b0;
      idle(10);

      // Simultaneous press on all channels
      Btt_in = '1;
      n = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (Btt_any) begin
            n = k;
            break;
         end
      end
      chk("all_lat", 32'(n), 32'(D + 3));
      chk("all_out", 32'(Btt_out), 32'('1 & {N{1'b1}}));
      tick();
      chk("all_any_off", 32'(Btt_any), 0);

      // Reset mid-repeat with buttons still pressed
      repeat_en = '1;
      idle(25);
      do_reset();
      wait_pulse(0, n);
      chk("post_rst_lat", 32'(n), 32'(D + 3));
      Btt_in    = '0;
      repeat_en = '0;
      idle(10);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 11) == 0) Btt_in[i] = ~Btt_in[i];
            if ($urandom_range(0, 59) == 0) repeat_en[i] = ~repeat_en[i];
         end
         if ($urandom_range(0, 799) == 0) do_reset();
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/button_shaper_array.md
BUTTON_SHAPER_ARRAY -- requirements
Module: button_shaper_array

Interface
REQ-001 SHALL have parameter NUM_BTN, default 4: number of independent button channels (1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples required to accept a press or a release (>=1).
REQ-003 SHALL have parameter REPEAT_DELAY, default 16: cycles held after the first pulse before the first auto-repeat pulse (>=1).
REQ-004 SHALL have parameter REPEAT_PERIOD, default 8: cycles held between later auto-repeat pulses (>=1).
REQ-005 SHALL have ports: clk  in  1  single clock, rising-edge; one clock, no other clock domains.
REQ-006 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports: Btt_in  in  NUM_BTN  raw asynchronous button levels, 1 = pressed.
REQ-008 SHALL have ports: repeat_en  in  NUM_BTN  per-channel auto-repeat enable, synchronous to clk.
REQ-009 SHALL have ports: Btt_out  out  NUM_BTN  per-channel one-cycle press pulse, registered.
REQ-010 SHALL have ports: Btt_level  out  NUM_BTN  per-channel debounced pressed level.
REQ-011 SHALL have ports: Btt_any  out  1  OR of all Btt_out bits.

Function
REQ-012 Each Btt_in bit SHALL pass through a 2-flop synchronizer; the second flop output (btn_s) alone drives that channel's FSM.
REQ-013 Each channel SHALL run an independent FSM with states IDLE, DEBOUNCE, PULSE, HELD, RELEASE and one counter sized for max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).
REQ-014 IDLE: btn_s=1 -> DEBOUNCE, cnt=0; else stay.
REQ-015 DEBOUNCE: btn_s=0 -> IDLE with no pulse; btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> PULSE, first_rep=1; else cnt+1.
REQ-016 PULSE: lasts exactly one cycle, then -> HELD with cnt=0, regardless of btn_s.
REQ-017 HELD: btn_s=0 -> RELEASE, cnt=0; repeat_en=0 -> stay, cnt=0; repeat_en=1 and cnt==limit-1 -> PULSE, first_rep=0; else cnt+1. limit = REPEAT_DELAY if first_rep, else REPEAT_PERIOD.
REQ-018 RELEASE: btn_s=1 -> HELD, cnt=0, first_rep kept; btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE; else cnt+1.
REQ-019 Btt_out[i] SHALL be 1 exactly when channel i is in PULSE; Btt_level[i] SHALL be 1 in PULSE, HELD and RELEASE.
REQ-020 Press latency: with Btt_in held high from sampling edge E1, Btt_out SHALL be high for the cycle after edge E(DEBOUNCE_CYCLES+3).
REQ-021 Auto-repeat spacing SHALL be REPEAT_DELAY+1 cycles from first to second pulse, then REPEAT_PERIOD+1 cycles between later pulses.
REQ-022 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never produce a pulse and SHALL never end a hold.
REQ-023 Channels SHALL not interact; simultaneous presses on several channels SHALL give simultaneous pulses.
REQ-024 Btt_any SHALL be combinational OR of the registered Btt_out bits.

Reset
REQ-025 While rst=1, asynchronously: all synchronizer flops 0, every FSM IDLE, counters 0, first_rep 0, so Btt_out, Btt_level and Btt_any are 0.
REQ-026 Reset asserted mid-hold or mid-pulse SHALL abort with no further pulse. After release, a still-pressed button SHALL need a full debounce before it pulses.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (3-bit localparams) and a clog2-based counter-width function.
REQ-028 The per-channel synchronizer plus FSM SHALL be sub-module button_shaper_channel, instantiated NUM_BTN times by generate.

Verification (clk period 20 ns, defaults unless stated)
REQ-029 Release rst; at 15 ns Btt_in[0]=1 and held -> Btt_out[0] one cycle high after the 7th rising edge, Btt_level[0]=1 from that cycle on.
REQ-030 Btt_in[1] high for 2 cycles, then low -> Btt_out[1] and Btt_level[1] stay 0 throughout.
REQ-031 repeat_en[2]=1, Btt_in[2] held 60 cycles -> pulses at T, T+17, T+26, T+35, ...; repeat_en[2]=0 -> exactly one pulse.
REQ-032 During a hold, Btt_in[0] low for 2 cycles -> Btt_level[0] stays 1 with no new pulse; low for 10 cycles -> Btt_level[0] falls.
REQ-033 Btt_in=4'b1111 pressed at once -> all four Btt_out bits pulse in the same cycle, Btt_any one cycle high.
REQ-034 rst=1 applied mid-repeat, with Btt_in still high -> outputs 0 at once; after rst=0 the first pulse comes 7 edges later.
